vec_deserializer: RTL



---
 rtl/vec_deserializer.sv | 122 ++++++++++++
 1 files changed

// File: rtl/vec_deserializer.sv
// vec_deserializer: packs LANES consecutive WIDTH-bit elements into one wide word.
// Receive side and send side are val/rdy handshakes. A new element is accepted in
// the same cycle that a finished word is released, so the stream has no bubbles.
// Optional feature macro: VEC_DESER_FLUSH_EN. When it is defined, the flush input
// emits a partially filled word. When it is undefined, flush is ignored.
module vec_deserializer #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned LANES = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [WIDTH-1:0]           recv_msg,
   input  logic                       recv_val,
   output logic                       recv_rdy,
   output logic [WIDTH*LANES-1:0]     send_msg,
   output logic                       send_val,
   input  logic                       send_rdy,
   output logic [$clog2(LANES):0]     send_cnt,
   input  logic                       flush
);

   localparam int unsigned CW    = $clog2(LANES);
   localparam int unsigned CNTW  = CW + 1;
   localparam int unsigned WORDW = WIDTH * LANES;

   typedef enum logic {
      FILL = 1'b0,
      SEND = 1'b1
   } state_t;

   state_t            r_state;
   logic [CW-1:0]     r_count;
   logic [WORDW-1:0]  r_data;
   logic [CNTW-1:0]   r_cnt;

   logic              w_recv_fire;
   logic              w_last;
   logic              w_flush;
   logic [WORDW-1:0]  w_fill_word;
   logic [WORDW-1:0]  w_first_word;

   // Accept when filling, or when the held word leaves in this same cycle
   assign recv_rdy    = (r_state == FILL) || ((r_state == SEND) && send_rdy);
   assign w_recv_fire = recv_val && recv_rdy;
   assign w_last      = (r_count == CW'(LANES - 1));

   assign send_msg    = r_data;
   assign send_val    = (r_state == SEND);
   assign send_cnt    = r_cnt;

`ifdef VEC_DESER_FLUSH_EN
   // Flush only makes sense once at least one lane holds data
   assign w_flush = flush && (r_count != '0);
`else
   logic w_unused_flush;
   assign w_unused_flush = flush;
   assign w_flush        = 1'b0;
`endif

   // A word that starts with the incoming element in lane 0 and all other lanes zero
   assign w_first_word = {{(WORDW - WIDTH){1'b0}}, recv_msg};

   // Write the incoming element into lane r_count. Starting a new word clears the other lanes.
   always_comb begin
      w_fill_word = '0;
      for (int k = 0; k < int'(LANES); k++) begin
         if (CW'(k) == r_count)
            w_fill_word[k*WIDTH +: WIDTH] = recv_msg;
         else if (r_count != '0)
            w_fill_word[k*WIDTH +: WIDTH] = r_data[k*WIDTH +: WIDTH];
      end
   end

   // Packing FSM: FILL collects lanes, SEND holds the word until the consumer takes it
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= FILL;
         r_count <= '0;
         r_data  <= '0;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            FILL: begin
               if (w_recv_fire) begin
                  r_data <= w_fill_word;
                  if (w_last || w_flush) begin
                     r_state <= SEND;
                     r_cnt   <= CNTW'(r_count) + CNTW'(1);
                     r_count <= '0;
                  end else begin
                     r_count <= r_count + CW'(1);
                  end
               end else if (w_flush) begin
                  r_state <= SEND;
                  r_cnt   <= CNTW'(r_count);
                  r_count <= '0;
               end
            end
            SEND: begin
               if (send_rdy) begin
                  r_state <= FILL;
                  r_cnt   <= '0;
                  if (w_recv_fire) begin
                     r_data  <= w_first_word;
                     r_count <= CW'(1);
                  end else begin
                     r_data  <= '0;
                     r_count <= '0;
                  end
               end
            end
            default: begin
               r_state <= FILL;
               r_count <= '0;
               r_data  <= '0;
               r_cnt   <= '0;
            end
         endcase
      end
   end

endmodule
